// File: rtl/spmmio_sdcard_seq_if.sv
// Register port of the SPI-mode SD shifter; the sequencer masters it.
interface spmmio_sdcard_seq_if;
  logic [0:3]  sd_adr;
  logic        sd_cs;
  logic [0:3]  sd_sel;
  logic        sd_we;
  logic [0:31] sd_d;
  logic [0:31] sd_q;

  modport master (output sd_adr, sd_cs, sd_sel, sd_we, sd_d, input sd_q);
  modport slave  (input sd_adr, sd_cs, sd_sel, sd_we, sd_d, output sd_q);
endinterface

// File: rtl/spmmio_sdcard_seq.sv
// SD command sequencer: divider, select, CMD+CRC7, R1 wait, optional 512-byte
// block read with CRC16 check, trailing clocks, deselect -- one per start pulse.
module spmmio_sdcard_seq #(
  parameter int unsigned RESP_TIMEOUT = 65535,
  parameter int unsigned TOKEN_TRIES  = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [0:5]  cmd_idx,
  input  logic [0:31] cmd_arg,
  input  logic        rd_block,
  input  logic [0:7]  divider,
  output logic        busy,
  output logic        done,
  output logic [0:1]  status,
  output logic [0:7]  r1,
  output logic [0:7]  dat,
  output logic        dat_valid,
  spmmio_sdcard_seq_if.master sd
);

  localparam int unsigned TW = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned CW = 10;

  typedef enum logic [3:0] {
    S_IDLE, S_SETDIV, S_DESEL, S_SEL, S_XWR, S_XPOLL,
    S_CRCRD, S_CRCCLR, S_CHK16, S_END
  } state_t;

  typedef enum logic [2:0] {
    P_CMD, P_CRC, P_R1, P_TOKEN, P_DATA, P_CRC16, P_TAIL
  } phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic [0:31]   arg_q, arg_d;
  logic [0:7]    tx_q, tx_d;
  logic          rd_q, rd_d;

  logic          busy_d, done_d, dat_valid_d;
  logic [0:1]    status_d;
  logic [0:7]    r1_d, dat_d;
  logic [0:3]    adr_d, sel_d;
  logic          cs_d, we_d;
  logic [0:31]   d_d;

  logic [0:7]    rx;
  logic          q_busy;
  logic          unused_q;

  assign rx       = sd.sd_q[24:31];
  assign q_busy   = sd.sd_q[23];
  assign unused_q = ^sd.sd_q[8:15];

  // Sequencing plus the bus operation to present next cycle
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    arg_d       = arg_q;
    tx_d        = tx_q;
    rd_d        = rd_q;
    busy_d      = busy;
    done_d      = 1'b0;
    status_d    = status;
    r1_d        = r1;
    dat_d       = dat;
    dat_valid_d = 1'b0;
    tcnt_inc    = (tcnt_q == '1) ? tcnt_q : tcnt_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        if (start && !done) begin
          arg_d    = cmd_arg;
          rd_d     = rd_block;
          tx_d     = {2'b01, cmd_idx};
          phase_d  = P_CMD;
          cnt_d    = '0;
          status_d = 2'd0;
          busy_d   = 1'b1;
          state_d  = S_SETDIV;
        end
      end
      S_SETDIV: state_d = S_DESEL;
      S_DESEL:  state_d = S_SEL;
      S_SEL:    state_d = S_XWR;
      S_XWR: begin
        tcnt_d  = tcnt_inc;
        state_d = S_XPOLL;
      end
      S_XPOLL: begin
        tcnt_d = tcnt_inc;
        if (q_busy) begin
          // R1 never arrived: the END write also stops the shifter
          if (phase_q == P_R1 && tcnt_q >= TW'(RESP_TIMEOUT)) begin
            status_d = 2'd1;
            state_d  = S_END;
          end
        end else begin
          state_d = S_XWR;
          tx_d    = 8'hFF;
          case (phase_q)
            P_CMD: begin
              if (cnt_q == CW'(4)) begin
                state_d = S_CRCRD;
              end else begin
                cnt_d = cnt_q + CW'(1);
                tx_d  = arg_q[0:7];
                arg_d = {arg_q[8:31], 8'h00};
              end
            end
            P_CRC: begin
              phase_d = P_R1;
              tcnt_d  = '0;
            end
            P_R1: begin
              r1_d = rx;
              if (!rd_q || rx != 8'h00) begin
                phase_d = P_TAIL;
              end else begin
                phase_d = P_TOKEN;
                cnt_d   = '0;
              end
            end
            P_TOKEN: begin
              if (rx == 8'hFE) begin
                state_d = S_CRCCLR;
              end else if (rx != 8'hFF || cnt_q == CW'(TOKEN_TRIES - 1)) begin
                status_d = 2'd2;
                phase_d  = P_TAIL;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
            P_DATA: begin
              dat_d       = rx;
              dat_valid_d = 1'b1;
              if (cnt_q == CW'(511)) begin
                phase_d = P_CRC16;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
            P_CRC16: begin
              if (cnt_q == CW'(1)) state_d = S_CHK16;
              else                 cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = S_END;
          endcase
        end
      end
      S_CRCRD: begin
        tx_d    = sd.sd_q[0:7];
        phase_d = P_CRC;
        state_d = S_XWR;
      end
      S_CRCCLR: begin
        phase_d = P_DATA;
        cnt_d   = '0;
        tx_d    = 8'hFF;
        state_d = S_XWR;
      end
      S_CHK16: begin
        if (sd.sd_q[16:31] != 16'h0000) status_d = 2'd3;
        phase_d = P_TAIL;
        tx_d    = 8'hFF;
        state_d = S_XWR;
      end
      S_END: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    adr_d = '0;
    cs_d  = 1'b0;
    we_d  = 1'b0;
    sel_d = '0;
    d_d   = '0;
    case (state_d)
      S_SETDIV: begin
        cs_d = 1'b1; we_d = 1'b1; sel_d = 4'b1000;
        d_d[0:7] = divider;
      end
      S_DESEL, S_END: begin
        cs_d = 1'b1; we_d = 1'b1; sel_d = 4'b0010;
      end
      S_SEL: begin
        cs_d = 1'b1; we_d = 1'b1; sel_d = 4'b0010;
        d_d[19] = 1'b1;
      end
      S_XWR: begin
        cs_d = 1'b1; we_d = 1'b1; sel_d = 4'b0011;
        d_d[19]    = 1'b1;
        d_d[22]    = (phase_d == P_R1);
        d_d[23]    = 1'b1;
        d_d[24:31] = tx_d;
      end
      S_XPOLL: begin
        cs_d = 1'b1; sel_d = 4'b1111;
      end
      S_CRCRD, S_CHK16: begin
        adr_d = 4'd1; cs_d = 1'b1; sel_d = 4'b1111;
      end
      S_CRCCLR: begin
        adr_d = 4'd1; cs_d = 1'b1; we_d = 1'b1; sel_d = 4'b0011;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      phase_q   <= P_CMD;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      arg_q     <= '0;
      tx_q      <= '0;
      rd_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      status    <= '0;
      r1        <= '0;
      dat       <= '0;
      dat_valid <= 1'b0;
      sd.sd_adr <= '0;
      sd.sd_cs  <= 1'b0;
      sd.sd_we  <= 1'b0;
      sd.sd_sel <= '0;
      sd.sd_d   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      arg_q     <= arg_d;
      tx_q      <= tx_d;
      rd_q      <= rd_d;
      busy      <= busy_d;
      done      <= done_d;
      status    <= status_d;
      r1        <= r1_d;
      dat       <= dat_d;
      dat_valid <= dat_valid_d;
      sd.sd_adr <= adr_d;
      sd.sd_cs  <= cs_d;
      sd.sd_we  <= we_d;
      sd.sd_sel <= sel_d;
      sd.sd_d   <= d_d;
    end
  end

endmodule

// File: tb/tb_spmmio_sdcard_seq.sv
// Bench for spmmio_sdcard_seq: behavioural SD shifter + card byte stream,
// directed transactions with hand-derived expectations.
module tb_spmmio_sdcard_seq;

  localparam int BYTE_CYC = 3;
  localparam int MQ       = 4096;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [0:5]  cmd_idx = '0;
  logic [0:31] cmd_arg = '0;
  logic        rd_block = 1'b0;
  logic [0:7]  divider = '0;
  logic        busy, done, dat_valid;
  logic [0:1]  status;
  logic [0:7]  r1, dat;

  spmmio_sdcard_seq_if sd_if ();

  spmmio_sdcard_seq #(.RESP_TIMEOUT(200), .TOKEN_TRIES(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cmd_idx(cmd_idx),
    .cmd_arg(cmd_arg), .rd_block(rd_block), .divider(divider),
    .busy(busy), .done(done), .status(status), .r1(r1), .dat(dat),
    .dat_valid(dat_valid), .sd(sd_if.master)
  );

  always #5 clk = ~clk;

  // Shifter + card model state
  logic       m_cs = 1'b0, m_busy = 1'b0, m_wait = 1'b0, m_last_cs = 1'b0;
  logic [7:0] m_div = '0, m_rx = '0;
  logic [6:0] m_crc7 = '0;
  logic [15:0] m_crc16 = '0;
  int         m_bcnt = 0;
  logic [7:0] miso_mem [MQ];
  int         miso_wr = 0, miso_rd = 0;
  logic [7:0] mosi_log [$];
  int         cyc = 0, r1_wr_cyc = 0, done_cyc = 0;
  int         dv_cnt = 0, dat_bad = 0, done_cnt = 0;
  int         n_chk = 0, n_fail = 0;

  function automatic logic [6:0] crc7_upd(input logic [6:0] c, input logic [7:0] b);
    logic [6:0] r = c;
    for (int i = 7; i >= 0; i--) begin
      logic fb = r[6] ^ b[i];
      r = {r[5:0], 1'b0};
      if (fb) r = r ^ 7'h09;
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r = c;
    for (int i = 7; i >= 0; i--) begin
      logic fb = r[15] ^ b[i];
      r = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  always_comb begin
    sd_if.sd_q = '0;
    if (sd_if.sd_adr == 4'd0) begin
      sd_if.sd_q[0:7]   = m_div;
      sd_if.sd_q[19]    = m_cs;
      sd_if.sd_q[22]    = m_wait;
      sd_if.sd_q[23]    = m_busy;
      sd_if.sd_q[24:31] = m_rx;
    end else if (sd_if.sd_adr == 4'd1) begin
      sd_if.sd_q[0:7]   = {m_crc7, 1'b1};
      sd_if.sd_q[16:31] = m_crc16;
    end
  end

  always @(posedge clk) begin : shifter
    logic [7:0] b;
    cyc <= cyc + 1;
    if (start && !busy) mosi_log.delete();
    if (sd_if.sd_cs && sd_if.sd_we) begin
      if (sd_if.sd_adr == 4'd0) begin
        if (sd_if.sd_sel[0]) m_div <= sd_if.sd_d[0:7];
        if (sd_if.sd_sel[2]) begin
          if (!m_cs) m_crc7 <= '0;
          m_cs   <= sd_if.sd_d[19];
          m_wait <= sd_if.sd_d[22];
          if (sd_if.sd_d[23] && sd_if.sd_sel[3]) begin
            m_busy <= 1'b1;
            m_bcnt <= BYTE_CYC;
            mosi_log.push_back(sd_if.sd_d[24:31]);
            if (m_cs) m_crc7 <= crc7_upd(m_crc7, sd_if.sd_d[24:31]);
            if (sd_if.sd_d[22]) r1_wr_cyc <= cyc;
          end else if (!sd_if.sd_d[23]) begin
            m_busy <= 1'b0;
          end
        end
      end else if (sd_if.sd_adr == 4'd1 && sd_if.sd_sel[2]) begin
        m_crc16 <= sd_if.sd_d[16:31];
      end
    end else if (m_busy) begin
      if (m_bcnt > 1) begin
        m_bcnt <= m_bcnt - 1;
      end else begin
        if (miso_rd != miso_wr) begin
          b = miso_mem[miso_rd % MQ];
          miso_rd <= miso_rd + 1;
        end else begin
          b = 8'hFF;
        end
        m_rx      <= b;
        m_crc16   <= crc16_upd(m_crc16, b);
        m_last_cs <= m_cs;
        if (m_wait && b[7]) m_bcnt <= BYTE_CYC;
        else                m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (start && !busy) begin
      dv_cnt = 0; dat_bad = 0; done_cnt = 0;
    end
    if (dat_valid) begin
      if (dat !== dv_cnt[7:0]) dat_bad++;
      dv_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] b);
    miso_mem[miso_wr % MQ] = b;
    miso_wr++;
  endtask

  task automatic flush_and_preamble();
    miso_wr = miso_rd;
    for (int i = 0; i < 6; i++) load(8'hFF);
  endtask

  task automatic load_block(input bit bad);
    logic [15:0] c = '0;
    for (int i = 0; i < 512; i++) begin
      load(8'(i));
      c = crc16_upd(c, 8'(i));
    end
    load(c[15:8]);
    load(bad ? (c[7:0] ^ 8'h01) : c[7:0]);
  endtask

  task automatic run(input logic [0:5] idx, input logic [0:31] arg, input logic rd,
                     input logic [0:7] div, input bit poke);
    bit seen = 1'b0;
    @(negedge clk);
    cmd_idx = idx; cmd_arg = arg; rd_block = rd; divider = div; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      start = poke && (i == 10);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!seen) check("done_wait", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({busy, done, status, r1, dat, dat_valid, sd_if.sd_cs, sd_if.sd_we,
                sd_if.sd_sel, sd_if.sd_adr, sd_if.sd_d});
  endfunction

  function automatic logic [63:0] mosi_head(input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[55:0], (i < mosi_log.size()) ? mosi_log[i] : 8'hxx};
    return v;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // CMD0: R1 0x01 after 3 fillers, with a stray start mid-transaction
    flush_and_preamble();
    load(8'hFF); load(8'hFF); load(8'hFF); load(8'h01);
    run(6'd0, 32'h0, 1'b0, 8'h00, 1'b1);
    check("cmd0_mosi", mosi_head(6), 64'h0000_4000_0000_0095);
    check("cmd0_nbytes", 64'(mosi_log.size()), 64'd8);
    check("cmd0_r1", 64'(r1), 64'h01);
    check("cmd0_status", 64'(status), 64'd0);
    check("cmd0_done_cnt", 64'(done_cnt), 64'd1);
    check("cmd0_tail_cs", 64'(m_last_cs), 64'd1);
    check("cmd0_end_cs", 64'(m_cs), 64'd0);

    // CMD17 good block
    flush_and_preamble();
    load(8'hFF); load(8'h00); load(8'hFF); load(8'hFF); load(8'hFE);
    load_block(1'b0);
    run(6'd17, 32'h0000_0200, 1'b1, 8'h10, 1'b0);
    check("cmd17_mosi", mosi_head(5), 64'h51_0000_0200);
    check("cmd17_div", 64'(m_div), 64'h10);
    check("cmd17_r1", 64'(r1), 64'h00);
    check("cmd17_dv_cnt", 64'(dv_cnt), 64'd512);
    check("cmd17_dat_order", 64'(dat_bad), 64'd0);
    check("cmd17_status", 64'(status), 64'd0);
    check("cmd17_done_cnt", 64'(done_cnt), 64'd1);

    // CMD17 corrupted CRC byte
    flush_and_preamble();
    load(8'hFF); load(8'h00); load(8'hFF); load(8'hFF); load(8'hFE);
    load_block(1'b1);
    run(6'd17, 32'h0000_0200, 1'b1, 8'h10, 1'b0);
    check("badcrc_dv_cnt", 64'(dv_cnt), 64'd512);
    check("badcrc_dat_order", 64'(dat_bad), 64'd0);
    check("badcrc_status", 64'(status), 64'd3);

    // No card: MISO stuck high
    flush_and_preamble();
    run(6'd0, 32'h0, 1'b0, 8'h00, 1'b0);
    check("nocard_status", 64'(status), 64'd1);
    check("nocard_window", 64'((done_cyc - r1_wr_cyc) >= 195 && (done_cyc - r1_wr_cyc) <= 210), 64'd1);
    check("nocard_shifter_busy", 64'(m_busy), 64'd0);
    check("nocard_cs", 64'(m_cs), 64'd0);

    // Error token instead of 0xFE
    flush_and_preamble();
    load(8'hFF); load(8'h00); load(8'h05);
    run(6'd17, 32'h0, 1'b1, 8'h00, 1'b0);
    check("errtok_status", 64'(status), 64'd2);
    check("errtok_dv_cnt", 64'(dv_cnt), 64'd0);

    // Token hunt exhausted: 5 cmd + crc + R1 + 4 token + tail
    flush_and_preamble();
    load(8'hFF); load(8'h00);
    run(6'd17, 32'h0, 1'b1, 8'h00, 1'b0);
    check("tries_status", 64'(status), 64'd2);
    check("tries_nbytes", 64'(mosi_log.size()), 64'd12);

    // Reset in the middle of the data phase, then a fresh CMD0
    flush_and_preamble();
    load(8'hFF); load(8'h00); load(8'hFE);
    load_block(1'b0);
    @(negedge clk);
    cmd_idx = 6'd17; cmd_arg = 32'h0; rd_block = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && dv_cnt < 100; i++) @(negedge clk);
    check("midreset_reached_data", 64'(dv_cnt >= 100), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midreset_outputs", out_vec(), 64'd0);
    repeat (6) @(negedge clk);
    flush_and_preamble();
    load(8'hFF); load(8'hFF); load(8'hFF); load(8'h01);
    reset_n = 1'b1;
    run(6'd0, 32'h0, 1'b0, 8'h00, 1'b0);
    check("postreset_status", 64'(status), 64'd0);
    check("postreset_r1", 64'(r1), 64'h01);
    check("postreset_mosi", mosi_head(6), 64'h0000_4000_0000_0095);
    check("postreset_done_cnt", 64'(done_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spmmio_sdcard_seq.md
# spmmio_sdcard_seq

Hardware command sequencer for the SPI-mode SD card MMIO shifter. It masters that peripheral's register port to perform one complete SD transaction per start pulse. A transaction is: set divider, select card, send a 6-byte command with hardware CRC7, wait for R1, and optionally receive a 512-byte data block with CRC16 check. It sits between the system-side storage logic and the SD shifter, replacing CPU byte-banging for block reads.

## Interface
Bit 0 is the MSB of every vector.
- RESP_TIMEOUT, 65535: clk cycles allowed for R1 (wait-for-zero byte) before abort.
- TOKEN_TRIES, 1023: max 0xFF filler bytes while hunting the 0xFE data token.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; ignored unless idle
- cmd_idx  in  6  SD command index
- cmd_arg  in  32  command argument
- rd_block  in  1  expect a data block after R1 == 0x00
- divider  in  8  SCK half-period divider, written to the shifter at start
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at completion
- status  out  2  0 OK, 1 R1 timeout, 2 token timeout/error token, 3 data CRC error; valid at done
- r1  out  8  received R1 byte
- dat  out  8  received data byte
- dat_valid  out  1  one-cycle strobe per data byte, no backpressure
- sd_adr  out  4  shifter register address
- sd_cs  out  1  shifter access strobe
- sd_sel  out  4  byte lanes
- sd_we  out  1  write enable
- sd_d  out  32  write data
- sd_q  in  32  read data, combinational on sd_adr

## Operation
Shifter map used:
- Word 0: d[0:7] divider (lane 0); d[19] card CS, d[22] wait-for-zero, d[23] go/busy (lane 2); d[24:31] tx byte on write / rx byte on read (lane 3).
- Word 1: q[0:7] = {crc7, 1}; d/q[16:31] crc16 (lanes 2–3).
- A lane-2 write to word 0 while CS is low clears CRC7.

Byte send ("XFER b, w"): one write to word 0 with lanes 2+3, d[19]=1, d[22]=w, d[23]=1, d[24:31]=b. Then read word 0 each cycle until q[23]=0; rx byte = q[24:31].

State sequence:
- IDLE: on start, latch inputs, busy=1.
- SETDIV: lane-0 write of divider.
- DESEL: lane-2 write, all zero (drops CS, stops any stale transfer).
- SEL: lane-2 write with d[19]=1 (clears CRC7).
- CMD: XFER {01,cmd_idx}, then cmd_arg bytes 0..3 MSB first, w=0.
- CRC: read word 1, XFER q[0:7], w=0.
- R1: XFER 0xFF, w=1. Cycles counted from the write. If the count reaches RESP_TIMEOUT with q[23] still 1, write word 0 lane 2 all-zero and go to END with status 1.
- R1 result: store r1. If !rd_block or r1≠0x00, go to TAIL with status 0.
- TOKEN: XFER 0xFF, w=0, repeatedly.
  - rx 0xFE → CRCCLR.
  - rx other than 0xFF → status 2, TAIL.
  - TOKEN_TRIES fillers exhausted → status 2, TAIL.
- CRCCLR: write word 1 lanes 2+3, zero.
- DATA: 512× XFER 0xFF; each rx byte drives dat with dat_valid for 1 cycle.
- CRC16: 2× XFER 0xFF. Then read word 1: q[16:31]≠0 → status 3, else 0.
- TAIL: XFER 0xFF (8 trailing clocks with CS high).
- END: lane-2 write all-zero (CS low). Then done=1 for one cycle, busy=0, back to IDLE.

Counters:
- Byte counter 10 bits; data count wraps only at 512 exactly.
- Timeout counter width ≥ clog2(RESP_TIMEOUT+1), saturating.

## Timing
- Reset values: busy 0, done 0, status 0, r1 0x00, dat 0x00, dat_valid 0, sd_cs 0, sd_we 0, sd_sel 0, sd_adr 0, sd_d 0. FSM to IDLE immediately and asynchronously.
- All sd_* outputs are registered. A write is one cycle with sd_cs=sd_we=1.
- First busy poll is in the cycle after the write. A poll is sd_cs=1, sd_we=0, sampled the same cycle.
- start to first bus write (SETDIV): 1 cycle.
- dat_valid asserts the cycle after the poll that sees q[23]=0.
- start while busy: ignored, no queuing. start in the same cycle as done: ignored.
- Reset mid-transaction: the shifter may be left busy or selected. The next transaction's DESEL recovers it; no other cleanup.

## Test plan
- CMD0 (idx 0, arg 0, divider 0x00, card model R1 0x01 after 3 filler bytes): MOSI bytes 40 00 00 00 00 95, r1=0x01, status 0, CS high through trailing byte, single done.
- CMD17 arg 0x00000200, model returns R1 0x00, 2 fillers, FE, bytes 0..511 = i mod 256, correct CRC16: 512 dat_valid strobes in order, status 0.
- Same as above with corrupted CRC byte: all 512 bytes delivered, status 3.
- No card (MISO stuck 1), RESP_TIMEOUT=200: done with status 1 within ~205 cycles of the R1 write; shifter busy cleared; CS low.
- Model sends error token 0x05 instead of FE: no dat_valid, status 2. Separately, TOKEN_TRIES=4 all 0xFF: exactly 4 token bytes, status 2.
- Assert reset_n low mid-DATA, then start a new CMD0: all outputs at reset values; new transaction completes normally with status 0.
